// File: rtl/vga_fill_master.sv
// Avalon-MM rectangle fill engine: a CSR slave programs a rectangle and colour,
// and a master port plots it one pixel word at a time in x-inner raster order.
module vga_fill_master #(
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam logic [7:0] XLAST = 8'(XMAX - 1);
  localparam logic [6:0] YLAST = 7'(YMAX - 1);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  state_t state, state_next;

  // Software-visible registers are kept as full words and read back verbatim.
  logic [31:0] p0_r, p1_r, colour_r, base_r;

  // Copies latched at start so CSR writes during a fill cannot disturb it.
  logic [7:0]  lx0, lx1c, cx;
  logic [6:0]  ly1c, cy;
  logic [7:0]  lcolour;
  logic [31:0] lbase;
  logic [14:0] count;

  logic [7:0] x0_f, x1c;
  logic [6:0] y0_f, y1c;
  logic       start, nonempty, accept, last;

  assign x0_f     = p0_r[23:16];
  assign y0_f     = p0_r[30:24];
  assign x1c      = (p1_r[23:16] > XLAST) ? XLAST : p1_r[23:16];
  assign y1c      = (p1_r[30:24] > YLAST) ? YLAST : p1_r[30:24];
  assign start    = write && (address == 4'd0) && (state == IDLE);
  assign nonempty = (x0_f <= x1c) && (y0_f <= y1c);
  assign accept   = (state == WRITE) && !m_waitrequest;
  assign last     = accept && (cx == lx1c) && (cy == ly1c);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && nonempty) state_next = WRITE;
      WRITE:   if (last)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    if (state == WRITE) begin
      m_write     = 1'b1;
      m_address   = lbase;
      m_writedata = {1'b0, cy, cx, 8'h00, lcolour};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p0_r     <= '0;
      p1_r     <= '0;
      colour_r <= '0;
      base_r   <= '0;
      lx0      <= '0;
      lx1c     <= '0;
      ly1c     <= '0;
      cx       <= '0;
      cy       <= '0;
      lcolour  <= '0;
      lbase    <= '0;
      count    <= '0;
    end else begin
      if (write) begin
        case (address)
          4'd1:    p0_r     <= writedata;
          4'd2:    p1_r     <= writedata;
          4'd3:    colour_r <= writedata;
          4'd4:    base_r   <= writedata;
          default: ;
        endcase
      end
      if (start) begin
        lx0     <= x0_f;
        lx1c    <= x1c;
        ly1c    <= y1c;
        cx      <= x0_f;
        cy      <= y0_f;
        lcolour <= colour_r[7:0];
        lbase   <= base_r;
        count   <= '0;
      end else if (accept) begin
        count <= count + 15'd1;
        if (cx < lx1c) begin
          cx <= cx + 8'd1;
        end else begin
          cx <= lx0;
          cy <= cy + 7'd1;
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (read && reset_n) begin
      case (address)
        4'd0:    readdata = {31'b0, state == WRITE};
        4'd1:    readdata = p0_r;
        4'd2:    readdata = p1_r;
        4'd3:    readdata = colour_r;
        4'd4:    readdata = base_r;
        4'd5:    readdata = {17'b0, count};
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: doc/vga_fill_master.md
Name: vga_fill_master

Overview:
- Avalon-MM master that fills an axis-aligned rectangle on the 160x120 monochrome frame buffer.
- Issues one pixel write per pixel to the VGA pixel-plot slave, using the same packed-word format the slave consumes.
- Software programs the rectangle and colour through an Avalon-MM slave CSR port, then starts the fill. The master port connects to the VGA slave's pixel register in the system interconnect.

Parameters:
- XMAX, 160, horizontal resolution; x1 clamped to XMAX-1
- YMAX, 120, vertical resolution; y1 clamped to YMAX-1

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- address  input  4  CSR word address (slave)
- read  input  1  CSR read strobe
- readdata  output  32  CSR read data, zero read latency
- write  input  1  CSR write strobe
- writedata  input  32  CSR write data
- m_address  output  32  master byte address
- m_write  output  1  master write request
- m_writedata  output  32  master pixel word
- m_waitrequest  input  1  slave stall; transfer completes on a cycle with m_write=1 and m_waitrequest=0

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- While reset_n=0 at a clk edge, all of the following are 0: CSRs, state (IDLE), m_write, m_address, m_writedata, pixel counter. readdata is 0 under reset.
- CSR map (word address):
  - 0 CTRL. Write of any data = start. Read = {31'b0, busy}.
  - 1 P0. [30:24]=y0, [23:16]=x0.
  - 2 P1. [30:24]=y1, [23:16]=x1.
  - 3 COLOUR. [7:0].
  - 4 BASE. VGA slave byte address.
  - 5 COUNT. Read only, [14:0] = pixels completed in the current or last fill.
  - All other addresses read 0; writes to them are ignored.
- readdata is combinational from address. Defined only while read=1; drive 0 otherwise.
- State IDLE, start seen:
  - Latch clamped coordinates: x1c=min(x1,XMAX-1), y1c=min(y1,YMAX-1).
  - Latch COLOUR and BASE; clear COUNT.
  - If x0>x1c or y0>y1c: stay IDLE, no transfers, COUNT=0.
  - Otherwise go to WRITE with cx=x0, cy=y0. m_write rises on the next cycle.
- State WRITE:
  - m_write=1, m_address=BASE latched.
  - m_writedata = {1'b0, cy[6:0], cx[7:0], 8'b0, colour[7:0]}.
  - While m_waitrequest=1, all master outputs are held stable.
  - On an accepted cycle, COUNT increments. Then:
    - if cx<x1c: cx=cx+1;
    - else cx=x0 and cy=cy+1;
    - if cx==x1c and cy==y1c: go to IDLE; m_write=0 next cycle.
- Busy: busy=1 exactly while in WRITE.
- Raster order: x inner, y outer. Latency from the start write to the first m_write assertion is 1 cycle.
- Start written while busy is ignored. CSR writes while busy update P0, P1, COLOUR and BASE but do not affect the active fill (latched copies).
- Start in the same cycle as the final accepted transfer is ignored, because the block is still busy.
- x0 or y0 outside the screen with x1c/y1c clamped gives x0>x1c or y0>y1c, hence no transfers.
- Coordinates use 8-bit x and 7-bit y. Comparisons are unsigned and no counter wraps; maximum COUNT is 19200.
- Reset mid-fill: m_write=0 on the edge where reset_n=0. The fill is abandoned and not resumed.

Test Plan:
- Basic fill: P0=(x2,y3), P1=(x4,y4), COLOUR=0xFF, BASE=0x100, start, m_waitrequest=0 -> 6 writes to 0x100 in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). First word 0x030200FF. busy drops the cycle after the 6th write; COUNT=6.
- Backpressure: same fill, m_waitrequest=1 for 3 cycles on the 2nd and 5th transfers -> outputs held stable during the stalls. Still exactly 6 accepted writes, no duplicates or skips.
- Clamp and empty:
  - P0=(158,118), P1=(200,127) -> 4 writes: (158,118),(159,118),(158,119),(159,119).
  - P0=(5,0), P1=(4,0) -> no writes, busy never 1, COUNT=0.
- Full screen: P0=(0,0), P1=(159,119) with random m_waitrequest -> COUNT=19200. Last word has x=159, y=119.
- Busy interactions: start plus new COLOUR=0x00 during a 4-pixel fill -> all 4 writes use the old colour and no second fill runs. A start after busy=0 uses 0x00.
- Reset mid-fill: reset_n=0 during the 3rd pixel stall -> m_write=0 and busy=0 next edge. COUNT reads 0 after reset release.
